// File: rtl/vga_fb_fetch_arbiter_if.sv
// Signal bundle between the VGA line-fetch arbiter, its timing generator, the pixel writer,
// the framebuffer RAM and the ping-pong line buffer.
interface vga_fb_fetch_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
);
  logic              line_req;
  logic [8:0]        line_idx;
  logic              busy;
  logic              done;
  logic              underrun;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              lb_we;
  logic              lb_bank;
  logic [7:0]        lb_addr;
  logic [DATA_W-1:0] lb_wdata;

  modport slave (
    input  line_req, line_idx, wr_valid, wr_addr, wr_data, ram_rdata,
    output busy, done, underrun, wr_ready, ram_addr, ram_we, ram_wdata,
           lb_we, lb_bank, lb_addr, lb_wdata
  );

  modport master (
    output line_req, line_idx, wr_valid, wr_addr, wr_data, ram_rdata,
    input  busy, done, underrun, wr_ready, ram_addr, ram_we, ram_wdata,
           lb_we, lb_bank, lb_addr, lb_wdata
  );
endinterface

// File: rtl/vga_fb_fetch_arbiter.sv
// Shares a single-port framebuffer RAM between the scan-line prefetcher and a pixel writer,
// copying one line into a ping-pong line buffer with writer slots interleaved on a fixed schedule.
module vga_fb_fetch_arbiter #(
  parameter int H_WORDS = 160,
  parameter int V_LINES = 480,
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 32,
  parameter int WR_SLOT = 4
) (
  input logic                   dclk,
  input logic                   clr_n,
  vga_fb_fetch_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int                SLOT_W   = (WR_SLOT < 1) ? 1 : $clog2(WR_SLOT + 1);
  localparam logic [7:0]        N_WORDS  = 8'(H_WORDS);
  localparam logic [7:0]        LAST_IDX = 8'(H_WORDS - 1);
  localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(WR_SLOT);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(H_WORDS);
  localparam logic [9:0]        LINE_LIM = 10'(V_LINES);
  localparam logic              SLOT_EN  = (WR_SLOT != 0);

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [7:0]        rd_cnt_reg;
  logic [SLOT_W-1:0] slot_cnt_reg;
  logic              drain_cnt_reg;
  logic              bank_reg;
  logic              underrun_reg;

  logic [ADDR_W-1:0] ram_addr_reg;
  logic              ram_we_reg;
  logic [DATA_W-1:0] ram_wdata_reg;
  logic              p1_vld_reg, p2_vld_reg;
  logic [7:0]        p1_idx_reg, p2_idx_reg;
  logic              lb_we_reg;
  logic              done_reg;
  logic [7:0]        lb_addr_reg;
  logic [DATA_W-1:0] lb_wdata_reg;

  logic fetch_open, slot_open, wr_ready, wr_accept, rd_issue, req_ok;

  // FETCH lingers one cycle after the final read decision while that address sits on the RAM bus.
  assign fetch_open = (state_reg == FETCH) && (rd_cnt_reg != N_WORDS);
  assign slot_open  = SLOT_EN && fetch_open && (slot_cnt_reg == SLOT_MAX);
  assign wr_ready   = (state_reg == IDLE) || (state_reg == DRAIN) || slot_open;
  assign wr_accept  = bus.wr_valid && wr_ready;
  assign rd_issue   = fetch_open && !wr_accept;
  assign req_ok     = bus.line_req && (state_reg == IDLE) && ({1'b0, bus.line_idx} < LINE_LIM);

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg     <= IDLE;
      base_reg      <= '0;
      rd_cnt_reg    <= '0;
      slot_cnt_reg  <= '0;
      drain_cnt_reg <= 1'b0;
      bank_reg      <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      underrun_reg <= bus.line_req && (state_reg != IDLE);
      case (state_reg)
        IDLE: begin
          if (req_ok) begin
            state_reg    <= FETCH;
            base_reg     <= ADDR_W'(bus.line_idx) * STRIDE;
            bank_reg     <= bus.line_idx[0];
            rd_cnt_reg   <= '0;
            slot_cnt_reg <= '0;
          end
        end
        FETCH: begin
          if (rd_issue) begin
            rd_cnt_reg <= rd_cnt_reg + 8'd1;
            if (slot_cnt_reg != SLOT_MAX)
              slot_cnt_reg <= slot_cnt_reg + SLOT_W'(1);
          end else if (wr_accept) begin
            slot_cnt_reg <= '0;
          end
          if (!fetch_open) begin
            state_reg     <= DRAIN;
            drain_cnt_reg <= 1'b0;
          end
        end
        DRAIN: begin
          drain_cnt_reg <= 1'b1;
          if (drain_cnt_reg)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // RAM issue stage followed by a two-deep tag pipe that lines up with the RAM read latency.
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      ram_addr_reg  <= '0;
      ram_we_reg    <= 1'b0;
      ram_wdata_reg <= '0;
      p1_vld_reg    <= 1'b0;
      p1_idx_reg    <= '0;
      p2_vld_reg    <= 1'b0;
      p2_idx_reg    <= '0;
      lb_we_reg     <= 1'b0;
      done_reg      <= 1'b0;
      lb_addr_reg   <= '0;
      lb_wdata_reg  <= '0;
    end else begin
      if (wr_accept) begin
        ram_addr_reg  <= bus.wr_addr;
        ram_we_reg    <= 1'b1;
        ram_wdata_reg <= bus.wr_data;
      end else begin
        ram_we_reg <= 1'b0;
        if (rd_issue)
          ram_addr_reg <= base_reg + ADDR_W'(rd_cnt_reg);
      end
      p1_vld_reg <= rd_issue;
      p1_idx_reg <= rd_cnt_reg;
      p2_vld_reg <= p1_vld_reg;
      p2_idx_reg <= p1_idx_reg;
      lb_we_reg  <= p2_vld_reg;
      done_reg   <= p2_vld_reg && (p2_idx_reg == LAST_IDX);
      if (p2_vld_reg) begin
        lb_addr_reg  <= p2_idx_reg;
        lb_wdata_reg <= bus.ram_rdata;
      end
    end
  end

  assign bus.busy      = (state_reg != IDLE);
  assign bus.done      = done_reg;
  assign bus.underrun  = underrun_reg;
  assign bus.wr_ready  = wr_ready;
  assign bus.ram_addr  = ram_addr_reg;
  assign bus.ram_we    = ram_we_reg;
  assign bus.ram_wdata = ram_wdata_reg;
  assign bus.lb_we     = lb_we_reg;
  assign bus.lb_bank   = bank_reg;
  assign bus.lb_addr   = lb_addr_reg;
  assign bus.lb_wdata  = lb_wdata_reg;
endmodule
